core_argmin_collector: RTL

CORE_ARGMIN_COLLECTOR -- requirements
Module: core_argmin_collector

---
 rtl/km_pkg.sv | 13 +
 rtl/core_next_sel.sv | 23 ++
 rtl/core_argmin_collector.sv | 130 +++++++++++++
 3 files changed

// File: rtl/km_pkg.sv
// rtl/km_pkg.sv - shared core-count constants and argmin FSM state encoding
package km_pkg;

  localparam int NUM_CORES  = 16;
  localparam int CORE_IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/core_next_sel.sv
// rtl/core_next_sel.sv - lowest set mask bit at or above a pointer, with none-left flag
module core_next_sel
  import km_pkg::*;
(
  input  logic [NUM_CORES-1:0]  i_mask,
  input  logic [CORE_IDX_W:0]   i_ptr,
  output logic [CORE_IDX_W-1:0] o_idx,
  output logic                  o_none
);

  // Descending walk so the last hit written is the lowest qualifying index.
  always_comb begin
    o_idx  = '0;
    o_none = 1'b1;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (i_mask[i] && ((CORE_IDX_W + 1)'(i) >= i_ptr)) begin
        o_idx  = CORE_IDX_W'(i);
        o_none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/core_argmin_collector.sv
// rtl/core_argmin_collector.sv - scans enabled cores and reports the minimum distance
module core_argmin_collector
  import km_pkg::*;
#(
  parameter int DIST_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NUM_CORES-1:0]  en,
  output logic [CORE_IDX_W-1:0] core_sel,
  output logic                  core_req,
  input  logic                  core_ack,
  input  logic [DIST_W-1:0]     core_dist,
  output logic                  busy,
  output logic                  done,
  output logic [CORE_IDX_W-1:0] min_core,
  output logic [CORE_IDX_W-1:0] min_cluster,
  output logic [DIST_W-1:0]     min_dist,
  output logic [CORE_IDX_W:0]   n_active
);

  state_t                  r_state;
  state_t                  w_next;
  logic [NUM_CORES-1:0]    r_mask;
  logic [CORE_IDX_W-1:0]   r_sel;
  logic [CORE_IDX_W-1:0]   r_ord;
  logic [CORE_IDX_W-1:0]   r_min_core;
  logic [CORE_IDX_W-1:0]   r_min_cluster;
  logic [DIST_W-1:0]       r_min_dist;
  logic [CORE_IDX_W:0]     r_n_active;

  logic [NUM_CORES-1:0]    w_mask;
  logic [CORE_IDX_W:0]     w_ptr;
  logic [CORE_IDX_W-1:0]   w_idx;
  logic                    w_none;
  logic [CORE_IDX_W:0]     w_pop;
  logic                    w_accept;

  // In IDLE the search looks at the incoming mask from 0; in SCAN it looks past the current core.
  assign w_mask   = (r_state == ST_IDLE) ? en : r_mask;
  assign w_ptr    = (r_state == ST_IDLE) ? '0 : ({1'b0, r_sel} + (CORE_IDX_W + 1)'(1));
  assign w_accept = (r_state == ST_SCAN) && core_ack;

  core_next_sel u_next_sel (
    .i_mask (w_mask),
    .i_ptr  (w_ptr),
    .o_idx  (w_idx),
    .o_none (w_none)
  );

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_pop = w_pop + {{CORE_IDX_W{1'b0}}, en[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    core_req = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = (en == '0) ? ST_DONE : ST_SCAN;
        end
      end
      ST_SCAN: begin
        core_req = 1'b1;
        busy     = 1'b1;
        if (core_ack && w_none) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask        <= '0;
      r_sel         <= '0;
      r_ord         <= '0;
      r_min_core    <= '0;
      r_min_cluster <= '0;
      r_min_dist    <= '1;
      r_n_active    <= '0;
    end else if (r_state == ST_IDLE) begin
      if (start) begin
        r_mask        <= en;
        r_n_active    <= w_pop;
        r_sel         <= w_idx;
        r_ord         <= '0;
        r_min_core    <= '0;
        r_min_cluster <= '0;
        r_min_dist    <= '1;
      end
    end else if (w_accept) begin
      // Strict compare in ascending core order keeps the lower index on ties.
      if (core_dist < r_min_dist) begin
        r_min_dist    <= core_dist;
        r_min_core    <= r_sel;
        r_min_cluster <= r_ord;
      end
      r_ord <= r_ord + CORE_IDX_W'(1);
      r_sel <= w_none ? '0 : w_idx;
    end
  end

  assign core_sel    = r_sel;
  assign min_core    = r_min_core;
  assign min_cluster = r_min_cluster;
  assign min_dist    = r_min_dist;
  assign n_active    = r_n_active;

endmodule
